// File: rtl/dma_pkg.sv
// dma_pkg: shared AXI encodings, FSM state type and burst-size helper for the activation DMA.
`default_nettype none

package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // AXI arsize encoding: log2 of the beat width in bytes.
  function automatic logic [2:0] axi_size(input int unsigned nbytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == nbytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/act_dma_2d_burst_planner.sv
// act_dma_2d_burst_planner: walks the 2-D tile row by row and presents the next AR burst,
// clipped to the burst cap, the remaining row beats and the next 4 KB page boundary.
`default_nettype none

module act_dma_2d_burst_planner
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int BYTES           = 8,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [AXI_ADDR_W-1:0] src_addr_i,
  input  logic [31:0]           row_bytes_i,
  input  logic [15:0]           row_count_i,
  input  logic [31:0]           row_stride_i,
  input  logic                  adv_i,
  output logic [AXI_ADDR_W-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic                  last_burst_o
);

  localparam int LOG2B = $clog2(BYTES);

  logic [AXI_ADDR_W-1:0] addr_q, row_base_q, stride_q;
  logic [31:0]           beats_left_q, row_beats_q;
  logic [15:0]           rows_left_q;

  logic [12:0]           page_beats;
  logic [31:0]           burst;
  logic                  row_end;
  logic [AXI_ADDR_W-1:0] step, next_base;

  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> LOG2B;

  always_comb begin
    burst = beats_left_q;
    if ({19'd0, page_beats} < burst)      burst = {19'd0, page_beats};
    if (32'(MAX_BURST_BEATS) < burst)     burst = 32'(MAX_BURST_BEATS);
  end

  assign row_end      = (beats_left_q == burst);
  assign last_burst_o = row_end && (rows_left_q == 16'd1);
  // beats_left is zero outside a transfer, so arlen rests at 0 rather than wrapping.
  assign arlen_o      = (burst == 32'd0) ? 8'd0 : 8'(burst - 32'd1);
  assign araddr_o     = addr_q;
  assign step         = AXI_ADDR_W'(burst << LOG2B);
  assign next_base    = row_base_q + stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      beats_left_q <= '0;
      row_beats_q  <= '0;
      rows_left_q  <= '0;
    end else if (load_i) begin
      addr_q       <= src_addr_i;
      row_base_q   <= src_addr_i;
      stride_q     <= AXI_ADDR_W'(row_stride_i);
      beats_left_q <= row_bytes_i >> LOG2B;
      row_beats_q  <= row_bytes_i >> LOG2B;
      rows_left_q  <= row_count_i;
    end else if (adv_i) begin
      if (row_end) begin
        rows_left_q  <= rows_left_q - 16'd1;
        row_base_q   <= next_base;
        addr_q       <= next_base;
        beats_left_q <= (rows_left_q == 16'd1) ? 32'd0 : row_beats_q;
      end else begin
        addr_q       <= addr_q + step;
        beats_left_q <= beats_left_q - burst;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/act_dma_2d.sv
// act_dma_2d: AXI4 read engine moving a 2-D activation tile into act_buffer, with abort and drain-on-error.
// Optional perf counters enabled by defining ACT_DMA_2D_PERF_EN.
`default_nettype none

module act_dma_2d
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_DATA_W      = 64,
  parameter int AXI_ID_W        = 4,
  parameter int STREAM_ID       = 1,
  parameter int MAX_BURST_BEATS = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BUF_ADDR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [AXI_ADDR_W-1:0] src_addr,
  input  logic [31:0]           row_bytes,
  input  logic [15:0]           row_count,
  input  logic [31:0]           row_stride,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [1:0]            err_resp,
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_ID_W-1:0]   m_axi_rid,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  buf_we,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [AXI_DATA_W-1:0] buf_wdata
`ifdef ACT_DMA_2D_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_beats
`endif
);

  localparam int BYTES = AXI_DATA_W / 8;

  state_t                state_q, state_d;
  logic [3:0]            outst_q;
  logic                  all_issued_q, error_q, buf_we_q;
  logic [1:0]            err_resp_q;
  logic [BUF_ADDR_W-1:0] buf_addr_q, wr_ptr_q;
  logic [AXI_DATA_W-1:0] buf_wdata_q;

  logic start_acc, cfg_ok, ar_ok, ar_hs, r_hs, r_bad, r_wr, last_burst;
  logic unused_rid;

  assign unused_rid = ^m_axi_rid;
  assign cfg_ok     = (row_bytes != 32'd0) && (row_count != 16'd0);
  assign start_acc  = (state_q == IDLE) && start;
  assign ar_ok      = (state_q == RUN) && !all_issued_q && (outst_q < 4'(MAX_OUTSTANDING));
  assign ar_hs      = ar_ok && m_axi_arready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign r_bad      = r_hs && (m_axi_rresp != AXI_RESP_OKAY);
  assign r_wr       = r_hs && (state_q == RUN) && (m_axi_rresp == AXI_RESP_OKAY);

  act_dma_2d_burst_planner #(
    .AXI_ADDR_W      (AXI_ADDR_W),
    .BYTES           (BYTES),
    .MAX_BURST_BEATS (MAX_BURST_BEATS)
  ) u_planner (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (start_acc),
    .src_addr_i   (src_addr),
    .row_bytes_i  (row_bytes),
    .row_count_i  (row_count),
    .row_stride_i (row_stride),
    .adv_i        (ar_hs),
    .araddr_o     (m_axi_araddr),
    .arlen_o      (m_axi_arlen),
    .last_burst_o (last_burst)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = cfg_ok ? RUN : DONE;
      RUN: begin
        if (abort || r_bad)                       state_d = DRAIN;
        else if (all_issued_q && outst_q == 4'd0) state_d = DONE;
      end
      DRAIN:   if (outst_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      outst_q      <= 4'd0;
      all_issued_q <= 1'b0;
      error_q      <= 1'b0;
      err_resp_q   <= 2'b00;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      wr_ptr_q     <= '0;
      buf_wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_we_q <= 1'b0;
      case ({ar_hs, r_hs && m_axi_rlast})
        2'b10:   outst_q <= outst_q + 4'd1;
        2'b01:   outst_q <= outst_q - 4'd1;
        default: outst_q <= outst_q;
      endcase
      if (start_acc) begin
        all_issued_q <= 1'b0;
        error_q      <= 1'b0;
        err_resp_q   <= 2'b00;
        buf_addr_q   <= '0;
        wr_ptr_q     <= '0;
      end else if (ar_hs && last_burst) begin
        all_issued_q <= 1'b1;
      end
      if (r_wr) begin
        buf_we_q    <= 1'b1;
        buf_addr_q  <= wr_ptr_q;
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        buf_wdata_q <= m_axi_rdata;
      end
      // Only the first bad response of a transfer is kept.
      if (r_bad && !error_q) begin
        error_q    <= 1'b1;
        err_resp_q <= m_axi_rresp;
      end
    end
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign err_resp      = err_resp_q;
  assign m_axi_arid    = AXI_ID_W'(STREAM_ID);
  assign m_axi_arsize  = axi_size(BYTES);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = ar_ok;
  assign m_axi_rready  = busy;
  assign buf_we        = buf_we_q;
  assign buf_addr      = buf_addr_q;
  assign buf_wdata     = buf_wdata_q;

`ifdef ACT_DMA_2D_PERF_EN
  logic [31:0] perf_busy_q, perf_beats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= 32'd0;
      perf_beats_q <= 32'd0;
    end else if (start_acc) begin
      perf_busy_q  <= 32'd0;
      perf_beats_q <= 32'd0;
    end else begin
      if (busy && perf_busy_q != 32'hFFFF_FFFF)      perf_busy_q  <= perf_busy_q + 32'd1;
      if (buf_we_q && perf_beats_q != 32'hFFFF_FFFF) perf_beats_q <= perf_beats_q + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_beats       = perf_beats_q;
`endif

endmodule

`default_nettype wire
